// File: rtl/seq_step_counter.sv
// Step-sequence counter over 0..LAST with restart, jump, pause, up/down direction and
// wrap-or-stop at the end index; done pulses for one cycle on each wrap or stop.
module seq_step_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LAST     = 4,
  parameter int unsigned JUMP_IDX = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             restart_i,
  input  logic             pause_i,
  input  logic             goto_jump_i,
  input  logic             dir_i,
  input  logic             wrap_en_i,
  output logic [WIDTH-1:0] out1_o,
  output logic [WIDTH-1:0] out2_o,
  output logic             odd_o,
  output logic             even_o,
  output logic             terminal_o,
  output logic             done_o
);

  if (LAST < 1 || LAST > (2 ** WIDTH) - 1) begin : g_bad_last
    $error("seq_step_counter: LAST out of range");
  end
  if (JUMP_IDX > LAST) begin : g_bad_jump
    $error("seq_step_counter: JUMP_IDX exceeds LAST");
  end

  localparam logic [WIDTH-1:0] LastIdx = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] JumpIdx = WIDTH'(JUMP_IDX);

  typedef enum logic [1:0] {StRun, StHold, StStop} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             done_q;

  logic [WIDTH-1:0] start_idx;
  logic [WIDTH-1:0] end_idx;
  logic             at_end;

  // Start and end swap with direction, so a dir change retargets on the same edge.
  always_comb begin
    start_idx = dir_i ? LastIdx : '0;
    end_idx   = dir_i ? '0 : LastIdx;
    at_end    = (cnt_q == end_idx);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (restart_i) begin
      state_q <= StRun;
      cnt_q   <= start_idx;
      done_q  <= 1'b0;
    end else if (goto_jump_i) begin
      state_q <= StRun;
      cnt_q   <= JumpIdx;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StStop: begin
          done_q <= 1'b0;
        end
        StRun, StHold: begin
          if (pause_i) begin
            state_q <= StHold;
            done_q  <= 1'b0;
          end else if (!at_end) begin
            state_q <= StRun;
            cnt_q   <= dir_i ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
            done_q  <= 1'b0;
          end else if (wrap_en_i) begin
            state_q <= StRun;
            cnt_q   <= start_idx;
            done_q  <= 1'b1;
          end else begin
            state_q <= StStop;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StRun;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out1_o     = cnt_q;
  assign out2_o     = LastIdx - cnt_q;
  assign odd_o      = cnt_q[0];
  assign even_o     = ~cnt_q[0];
  assign terminal_o = at_end;
  assign done_o     = done_q;

endmodule
